// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control register bank with RW registers, per-register write pulses and RO status words.
// Optional macro AXIL_CTRL_SLVERR_EN: SLVERR on writes to RO/unmapped words and reads of unmapped.
module axil_ctrl_regs #(
  parameter int unsigned C_S_AXI_CONTROL_ADDR_WIDTH = 12,
  parameter int unsigned C_S_AXI_CONTROL_DATA_WIDTH = 32,
  parameter int unsigned NUM_RW_REGS                = 8,
  parameter int unsigned NUM_RO_REGS                = 4
) (
  input  logic                                            ap_clk,
  input  logic                                            ap_rst,
  input  logic                                            s_axi_control_awvalid,
  output logic                                            s_axi_control_awready,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]           s_axi_control_awaddr,
  input  logic                                            s_axi_control_wvalid,
  output logic                                            s_axi_control_wready,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]           s_axi_control_wdata,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0]         s_axi_control_wstrb,
  output logic                                            s_axi_control_bvalid,
  input  logic                                            s_axi_control_bready,
  output logic [1:0]                                      s_axi_control_bresp,
  input  logic                                            s_axi_control_arvalid,
  output logic                                            s_axi_control_arready,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]           s_axi_control_araddr,
  output logic                                            s_axi_control_rvalid,
  input  logic                                            s_axi_control_rready,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]           s_axi_control_rdata,
  output logic [1:0]                                      s_axi_control_rresp,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH*NUM_RW_REGS-1:0] regs_out,
  output logic [NUM_RW_REGS-1:0]                          reg_wr_pulse,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH*NUM_RO_REGS-1:0] status_in
);

  localparam int unsigned AW = C_S_AXI_CONTROL_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_CONTROL_DATA_WIDTH;
  localparam int unsigned IW = AW - 2;

  typedef enum logic [1:0] {
    WrIdle = 2'd0,
    WrData = 2'd1,
    WrResp = 2'd2,
    WrRst  = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RdIdle = 2'd0,
    RdData = 2'd1,
    RdRst  = 2'd3
  } rd_state_e;

  wr_state_e             wstate_q, wstate_d;
  rd_state_e             rstate_q, rstate_d;
  logic [IW-1:0]         waddr_q, waddr_d;
  logic [DW-1:0]         regs_q [NUM_RW_REGS];
  logic [DW-1:0]         regs_d [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [IW-1:0]         rd_idx;

  // Byte offset within a word carries no meaning for word-aligned registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

  assign rd_idx = s_axi_control_araddr[AW-1:2];

`ifdef AXIL_CTRL_SLVERR_EN
  localparam logic [IW-1:0] RwEnd = IW'(NUM_RW_REGS);
  localparam logic [IW-1:0] RoEnd = IW'(NUM_RW_REGS + NUM_RO_REGS);
  logic [1:0] bresp_q, bresp_d;
  logic [1:0] rresp_q, rresp_d;
`endif

  always_comb begin
    wstate_d   = wstate_q;
    waddr_d    = waddr_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
`ifdef AXIL_CTRL_SLVERR_EN
    bresp_d    = bresp_q;
`endif
    unique case (wstate_q)
      WrIdle: begin
        if (s_axi_control_awvalid) begin
          waddr_d  = s_axi_control_awaddr[AW-1:2];
          wstate_d = WrData;
        end
      end
      WrData: begin
        if (s_axi_control_wvalid) begin
          for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (waddr_q == IW'(i)) begin
              for (int b = 0; b < DW / 8; b++) begin
                if (s_axi_control_wstrb[b]) regs_d[i][8*b +: 8] = s_axi_control_wdata[8*b +: 8];
              end
              wr_pulse_d[i] = 1'b1;
            end
          end
`ifdef AXIL_CTRL_SLVERR_EN
          bresp_d = (waddr_q < RwEnd) ? 2'b00 : 2'b10;
`endif
          wstate_d = WrResp;
        end
      end
      WrResp: begin
        if (s_axi_control_bready) wstate_d = WrIdle;
      end
      default: wstate_d = WrIdle;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
`ifdef AXIL_CTRL_SLVERR_EN
    rresp_d  = rresp_q;
`endif
    unique case (rstate_q)
      RdIdle: begin
        if (s_axi_control_arvalid) begin
          rdata_d = '0;
          for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (rd_idx == IW'(i)) rdata_d = regs_q[i];
          end
          for (int k = 0; k < NUM_RO_REGS; k++) begin
            if (rd_idx == IW'(NUM_RW_REGS + k)) rdata_d = status_in[DW*k +: DW];
          end
`ifdef AXIL_CTRL_SLVERR_EN
          rresp_d = (rd_idx < RoEnd) ? 2'b00 : 2'b10;
`endif
          rstate_d = RdData;
        end
      end
      RdData: begin
        if (s_axi_control_rready) rstate_d = RdIdle;
      end
      default: rstate_d = RdIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wstate_q   <= WrRst;
      rstate_q   <= RdRst;
      waddr_q    <= '0;
      regs_q     <= '{default: '0};
      wr_pulse_q <= '0;
      rdata_q    <= '0;
`ifdef AXIL_CTRL_SLVERR_EN
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
`endif
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      waddr_q    <= waddr_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
`ifdef AXIL_CTRL_SLVERR_EN
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
`endif
    end
  end

  assign s_axi_control_awready = (wstate_q == WrIdle);
  assign s_axi_control_wready  = (wstate_q == WrData);
  assign s_axi_control_bvalid  = (wstate_q == WrResp);
  assign s_axi_control_arready = (rstate_q == RdIdle);
  assign s_axi_control_rvalid  = (rstate_q == RdData);
  assign s_axi_control_rdata   = rdata_q;
  assign reg_wr_pulse          = wr_pulse_q;

`ifdef AXIL_CTRL_SLVERR_EN
  assign s_axi_control_bresp = bresp_q;
  assign s_axi_control_rresp = rresp_q;
`else
  assign s_axi_control_bresp = 2'b00;
  assign s_axi_control_rresp = 2'b00;
`endif

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_regs_out
    assign regs_out[DW*g +: DW] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Randomized self-checking bench for axil_ctrl_regs against an array-based register-map model.
module tb_axil_ctrl_regs;
  localparam int AW  = 12;
  localparam int NRW = 8;
  localparam int NRO = 4;

`ifdef AXIL_CTRL_SLVERR_EN
  localparam logic [1:0] ErrResp = 2'b10;
`else
  localparam logic [1:0] ErrResp = 2'b00;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [32*NRW-1:0] regs_out;
  logic [NRW-1:0]    reg_wr_pulse;
  logic [32*NRO-1:0] status_in;

  axil_ctrl_regs dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .s_axi_control_awvalid (awvalid),
    .s_axi_control_awready (awready),
    .s_axi_control_awaddr  (awaddr),
    .s_axi_control_wvalid  (wvalid),
    .s_axi_control_wready  (wready),
    .s_axi_control_wdata   (wdata),
    .s_axi_control_wstrb   (wstrb),
    .s_axi_control_bvalid  (bvalid),
    .s_axi_control_bready  (bready),
    .s_axi_control_bresp   (bresp),
    .s_axi_control_arvalid (arvalid),
    .s_axi_control_arready (arready),
    .s_axi_control_araddr  (araddr),
    .s_axi_control_rvalid  (rvalid),
    .s_axi_control_rready  (rready),
    .s_axi_control_rdata   (rdata),
    .s_axi_control_rresp   (rresp),
    .regs_out              (regs_out),
    .reg_wr_pulse          (reg_wr_pulse),
    .status_in             (status_in)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl_rw [NRW];
  logic [31:0] mdl_st [NRO];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
    int i = widx(a);
    if (i < NRW) return mdl_rw[i];
    if (i < NRW + NRO) return mdl_st[i - NRW];
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [AW-1:0] a);
    return (widx(a) < NRW + NRO) ? 2'b00 : ErrResp;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [AW-1:0] a);
    return (widx(a) < NRW) ? 2'b00 : ErrResp;
  endfunction

  task automatic drive_status();
    for (int k = 0; k < NRO; k++) status_in[32*k +: 32] = mdl_st[k];
  endtask

  task automatic check_regs();
    for (int i = 0; i < NRW; i++)
      check($sformatf("regs_out[%0d]", i), 64'(regs_out[32*i +: 32]), 64'(mdl_rw[i]));
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = widx(a);
    if (i < NRW)
      for (int b = 0; b < 4; b++) if (s[b]) mdl_rw[i][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold);
    int n = 0;
    logic [NRW-1:0] pexp = '0;
    @(negedge ap_clk);
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge ap_clk); n++; end
    check("wr_awready", 64'(awready), 64'(1));
    @(negedge ap_clk);
    awvalid = 1'b0;
    check("wr_wready", 64'(wready), 64'(1));
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge ap_clk);
    wvalid = 1'b0;
    model_write(a, d, s);
    if (widx(a) < NRW) pexp[widx(a)] = 1'b1;
    check("wr_bvalid", 64'(bvalid), 64'(1));
    check("wr_bresp", 64'(bresp), 64'(exp_bresp(a)));
    check("wr_pulse", 64'(reg_wr_pulse), 64'(pexp));
    for (int c = 0; c < hold; c++) begin
      bready = 1'b0;
      @(negedge ap_clk);
      check("wr_hold_bvalid", 64'(bvalid), 64'(1));
      check("wr_hold_awready", 64'(awready), 64'(0));
      check("wr_hold_pulse", 64'(reg_wr_pulse), 64'(0));
    end
    bready = 1'b1;
    @(negedge ap_clk);
    bready = 1'b0;
    check("wr_bvalid_drop", 64'(bvalid), 64'(0));
    check("wr_pulse_drop", 64'(reg_wr_pulse), 64'(0));
    check("wr_back_idle", 64'(awready), 64'(1));
    check_regs();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int hold);
    int n = 0;
    logic [31:0] exp;
    @(negedge ap_clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge ap_clk); n++; end
    check("rd_arready", 64'(arready), 64'(1));
    exp = exp_rdata(a);
    @(negedge ap_clk);
    arvalid = 1'b0;
    check("rd_rvalid", 64'(rvalid), 64'(1));
    check("rd_rdata", 64'(rdata), 64'(exp));
    check("rd_rresp", 64'(rresp), 64'(exp_rresp(a)));
    for (int c = 0; c < hold; c++) begin
      rready = 1'b0;
      for (int k = 0; k < NRO; k++) mdl_st[k] = $urandom;
      drive_status();
      @(negedge ap_clk);
      check("rd_hold_rvalid", 64'(rvalid), 64'(1));
      check("rd_hold_rdata", 64'(rdata), 64'(exp));
      check("rd_hold_arready", 64'(arready), 64'(0));
    end
    rready = 1'b1;
    @(negedge ap_clk);
    rready = 1'b0;
    check("rd_rvalid_drop", 64'(rvalid), 64'(0));
    check("rd_back_idle", 64'(arready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [31:0] old;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int k = 0; k < NRO; k++) mdl_st[k] = $urandom;
    for (int i = 0; i < NRW; i++) mdl_rw[i] = '0;
    drive_status();

    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_pulse", 64'(reg_wr_pulse), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_resp", 64'({bresp, rresp}), 64'(0));
    check("rst_regs_zero", 64'(|regs_out), 64'(0));
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rel_awready", 64'(awready), 64'(1));
    check("rel_arready", 64'(arready), 64'(1));

    axi_write(12'h010, 32'h1234_5678, 4'hF, 0);
    check("reg4_value", 64'(regs_out[159:128]), 64'h1234_5678);
    axi_read(12'h010, 0);

    axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(12'h000, 32'h0000_0000, 4'b0101, 0);
    check("strb_0101", 64'(regs_out[31:0]), 64'hFF00_FF00);
    axi_read(12'h000, 0);

    mdl_st[1] = 32'hCAFE_F00D;
    drive_status();
    axi_read(12'h024, 0);
    axi_write(12'h024, 32'hDEAD_BEEF, 4'hF, 0);
    axi_read(12'h100, 0);
    axi_write(12'h100, 32'h5555_AAAA, 4'hF, 0);
    axi_write(12'h008, 32'hFFFF_FFFF, 4'h0, 0);

    axi_write(12'h014, 32'hA5A5_0F0F, 4'hF, 5);
    axi_read(12'h014, 5);

    // W offered during the address phase must not be taken until WR_DATA.
    @(negedge ap_clk);
    awaddr = 12'h004; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
    check("w_idle_wready", 64'(wready), 64'(0));
    @(negedge ap_clk);
    awvalid = 1'b0; wdata = 32'h600D_600D;
    @(negedge ap_clk);
    wvalid = 1'b0;
    model_write(12'h004, 32'h600D_600D, 4'hF);
    check("w_late_bvalid", 64'(bvalid), 64'(1));
    bready = 1'b1;
    @(negedge ap_clk);
    bready = 1'b0;
    check_regs();

    // W and AR handshakes coincide on one address: read sees the old value.
    old = mdl_rw[7];
    @(negedge ap_clk);
    awaddr = 12'h01C; awvalid = 1'b1;
    @(negedge ap_clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    araddr = 12'h01C; arvalid = 1'b1;
    @(negedge ap_clk);
    wvalid = 1'b0; arvalid = 1'b0;
    model_write(12'h01C, 32'h1357_9BDF, 4'hF);
    check("race_rvalid", 64'(rvalid), 64'(1));
    check("race_bvalid", 64'(bvalid), 64'(1));
    check("race_old_rdata", 64'(rdata), 64'(old));
    bready = 1'b1; rready = 1'b1;
    @(negedge ap_clk);
    bready = 1'b0; rready = 1'b0;
    check("race_idle", 64'({awready, arready}), 64'(3));
    check_regs();

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 4) == 0) a = AW'($urandom);
      else a = AW'($urandom_range(0, NRW + NRO + 1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2));
      end else begin
        for (int k = 0; k < NRO; k++) mdl_st[k] = $urandom;
        drive_status();
        axi_read(a, $urandom_range(0, 2));
      end
    end

    // Reset while a write sits in WR_DATA.
    @(negedge ap_clk);
    awaddr = 12'h00C; awvalid = 1'b1;
    @(negedge ap_clk);
    awvalid = 1'b0;
    check("mid_wready", 64'(wready), 64'(1));
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("mid_wstate", 64'(dut.wstate_q), 64'(3));
    check("mid_ready", 64'({awready, wready, arready}), 64'(0));
    check("mid_valid", 64'({bvalid, rvalid}), 64'(0));
    check("mid_pulse", 64'(reg_wr_pulse), 64'(0));
    check("mid_rdata", 64'(rdata), 64'(0));
    check("mid_regs_zero", 64'(|regs_out), 64'(0));
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("mid_rel_awready", 64'(awready), 64'(1));
    for (int i = 0; i < NRW; i++) mdl_rw[i] = '0;
    axi_read(12'h00C, 0);
    axi_read(12'h010, 0);
    check_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
